// File: rtl/hazard_pkg.sv
// Shared encodings for the forwarding/hazard unit and its per-source comparator.
package hazard_pkg;

    // Forwarding select encodings seen by the EX-stage operand muxes
    localparam logic [1:0] SEL_RF  = 2'b00;  // operand comes from the register file
    localparam logic [1:0] SEL_MEM = 2'b01;  // operand comes from the MEM-stage result
    localparam logic [1:0] SEL_WB  = 2'b10;  // operand comes from the WB-stage result

    // Register ID that never produces a match (the PC); 2**REG_W disables it
    localparam int DEFAULT_IGNORE_REG = 15;

endpackage

// File: rtl/fwd_src_cmp.sv
// Per-source comparator: tests one ID-stage source against the EX and MEM
// destinations and proposes the forwarding select for that source.
module fwd_src_cmp
    import hazard_pkg::*;
#(
    parameter int REG_W      = 4,
    parameter int IGNORE_REG = DEFAULT_IGNORE_REG
) (
    input  logic             id_valid,
    input  logic [REG_W-1:0] src,
    input  logic             src_valid,
    input  logic [REG_W-1:0] ex_dest,
    input  logic             ex_wb_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    output logic             match_ex,
    output logic             match_mem,
    output logic [1:0]       next_sel
);

    logic src_live;

    // A source can only match when it is really read and is not the ignored ID
    assign src_live = id_valid & src_valid & (int'(src) != IGNORE_REG);

    // Compare against both producers; the EX instruction is younger and wins
    always_comb begin
        match_ex  = src_live & ex_wb_en  & (src == ex_dest);
        match_mem = src_live & mem_wb_en & (src == mem_dest);
        if (match_ex)
            next_sel = SEL_MEM;
        else if (match_mem)
            next_sel = SEL_WB;
        else
            next_sel = SEL_RF;
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard control: evaluates ID sources one cycle early,
// registers EX-aligned forwarding selects, detects stalls, counts stall
// cycles and watches for runs of consecutive stalls.
module fwd_hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_W      = 4,
    parameter int NUM_SRC    = 2,
    parameter int IGNORE_REG = DEFAULT_IGNORE_REG,
    parameter int CNT_W      = 16,
    parameter int MAX_STALL  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fwd_en,
    input  logic                     flush,
    input  logic                     id_valid,
    input  logic [NUM_SRC*REG_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]       id_src_valid,
    input  logic [REG_W-1:0]         ex_dest,
    input  logic                     ex_wb_en,
    input  logic                     ex_mem_read,
    input  logic [REG_W-1:0]         mem_dest,
    input  logic                     mem_wb_en,
    output logic [NUM_SRC*2-1:0]     sel_src,
    output logic                     hazard_stall,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic                     stall_timeout
);

    localparam int WD_W = $clog2(MAX_STALL + 1);

    logic [NUM_SRC-1:0]   match_ex;
    logic [NUM_SRC-1:0]   match_mem;
    logic [NUM_SRC*2-1:0] next_sel;
    logic [WD_W-1:0]      consec_cnt;
    logic                 load_use;
    logic                 any_raw;

    // Saturating increment: holds at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_src_cmp #(
            .REG_W      (REG_W),
            .IGNORE_REG (IGNORE_REG)
        ) u_cmp (
            .id_valid  (id_valid),
            .src       (id_src[i*REG_W +: REG_W]),
            .src_valid (id_src_valid[i]),
            .ex_dest   (ex_dest),
            .ex_wb_en  (ex_wb_en),
            .mem_dest  (mem_dest),
            .mem_wb_en (mem_wb_en),
            .match_ex  (match_ex[i]),
            .match_mem (match_mem[i]),
            .next_sel  (next_sel[i*2 +: 2])
        );
    end

    // Stall decision: load-use only when forwarding, any RAW otherwise; flush overrides
    always_comb begin
        load_use     = (|match_ex) & ex_mem_read;
        any_raw      = |(match_ex | match_mem);
        hazard_stall = ~flush & (fwd_en ? load_use : any_raw);
    end

    // ID->EX select register: a flushed, stalled or non-forwarding slot reads the regfile
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sel_src <= '0;
        else if (flush || hazard_stall || !fwd_en)
            sel_src <= '0;
        else
            sel_src <= next_sel;
    end

    // Performance counter of stall cycles, saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (hazard_stall)
            stall_cnt <= sat_inc(stall_cnt);
    end

    // Watchdog: count consecutive stalls and latch the timeout once MAX_STALL is reached
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            consec_cnt    <= '0;
            stall_timeout <= 1'b0;
        end else if (hazard_stall) begin
            if (consec_cnt != WD_W'(MAX_STALL))
                consec_cnt <= consec_cnt + 1'b1;
            if (consec_cnt >= WD_W'(MAX_STALL - 1))
                stall_timeout <= 1'b1;
        end else begin
            consec_cnt <= '0;
        end
    end

endmodule
